// File: rtl/hdmuxb4_rr_sched_if.sv
// -----------------------------------------------------------------------------
// hdmuxb4_rr_sched_if
// Bundle of requester, consumer and mux-select signals around the round-robin
// scheduler for a shared HDMUXB4DL inverting mux bank.
//
//   req   [3:0]  request per requester, held high while its data is valid
//   last  [3:0]  per-requester last-beat flag, only meaningful under its grant
//   rdy          consumer accepts the current beat
//   sl0, sl1     mux select bits driven to the bank (registered)
//   gnt   [3:0]  one-hot grant (registered)
//   vld          beat valid toward the consumer
//   busy         scheduler is not idle
//
// The master modport is the scheduler side; the slave modport is the
// requester/consumer side.
// -----------------------------------------------------------------------------
interface hdmuxb4_rr_sched_if;
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic       sl0;
    logic       sl1;
    logic [3:0] gnt;
    logic       vld;
    logic       busy;

    modport master (
        input  req, last, rdy,
        output sl0, sl1, gnt, vld, busy
    );

    modport slave (
        output req, last, rdy,
        input  sl0, sl1, gnt, vld, busy
    );
endinterface

// File: rtl/hdmuxb4_rr_sched.sv
// -----------------------------------------------------------------------------
// hdmuxb4_rr_sched
// Round-robin scheduler sharing a bank of HDMUXB4DL cells (Z = ~A[SL1:SL0])
// between four requesters. It drives the bank select, issues one-hot grants,
// qualifies beats toward the consumer with a valid/ready handshake, and inserts
// TURN_CYC settle cycles whenever the select has to move.
//
// Parameters
//   MAXBEATS  beats allowed per grant before a forced release (1..255)
//   TURN_CYC  settle cycles after a select change (0..7, 0 skips TURN)
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   hdmuxb4_rr_sched_if.master (req/last/rdy in, sl0/sl1/gnt/vld/busy out)
// -----------------------------------------------------------------------------
module hdmuxb4_rr_sched #(
    parameter int MAXBEATS = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    hdmuxb4_rr_sched_if.master         bus
);

    localparam int BW = $clog2(MAXBEATS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      sel;
    logic [3:0]      gnt;
    logic [1:0]      ptr;
    logic [1:0]      win;
    logic [BW-1:0]   beat_cnt;
    logic [2:0]      turn_cnt;

    logic [1:0]      base;
    logic [1:0]      idx;
    logic [1:0]      next_w;
    logic            any_req;
    logic            transfer;
    logic            hit_max;
    logic            release_now;
    logic            turn_done;

    // Winner search. While granting, the pointer used is the current winner,
    // because on release the pointer moves to it on that very edge; the
    // still-asserted request of the current winner is scanned last, so it only
    // re-wins when nobody else is waiting.
    always_comb begin
        base    = (state == GRANT) ? win : ptr;
        idx     = '0;
        next_w  = base;
        any_req = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (bus.req[idx]) begin
                any_req = 1'b1;
                next_w  = idx;
            end
        end
    end

    // Beat handshake and release decision for the granted requester.
    always_comb begin
        transfer    = bus.vld & bus.rdy;
        hit_max     = (beat_cnt + BW'(1)) == BW'(MAXBEATS);
        release_now = (state == GRANT) &&
                      ((transfer && (bus.last[win] || hit_max)) || !bus.req[win]);
        turn_done   = (int'(turn_cnt) + 1) >= TURN_CYC;
    end

    // Main scheduler FSM: select, grant, pointer and counters all move together
    // so the select can never change underneath a live grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 2'b00;
            gnt      <= 4'b0000;
            ptr      <= 2'd3;
            win      <= 2'd0;
            beat_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win <= next_w;
                        if (next_w == sel || TURN_CYC == 0) begin
                            state <= GRANT;
                            sel   <= next_w;
                            gnt   <= 4'b0001 << next_w;
                        end else begin
                            state    <= TURN;
                            sel      <= next_w;
                            turn_cnt <= '0;
                        end
                    end
                end

                TURN: begin
                    turn_cnt <= turn_cnt + 3'd1;
                    if (turn_done) begin
                        turn_cnt <= '0;
                        if (bus.req[win]) begin
                            state <= GRANT;
                            gnt   <= 4'b0001 << win;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                GRANT: begin
                    if (transfer) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                    if (release_now) begin
                        ptr      <= win;
                        beat_cnt <= '0;
                        if (!any_req) begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                        end else if (next_w == win || TURN_CYC == 0) begin
                            win <= next_w;
                            sel <= next_w;
                            gnt <= 4'b0001 << next_w;
                        end else begin
                            state    <= TURN;
                            win      <= next_w;
                            sel      <= next_w;
                            gnt      <= 4'b0000;
                            turn_cnt <= '0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                end
            endcase
        end
    end

    // Outputs: valid is combinational on the live request so a dropped request
    // never presents a beat.
    assign bus.sl0  = sel[0];
    assign bus.sl1  = sel[1];
    assign bus.gnt  = gnt;
    assign bus.vld  = |(gnt & bus.req);
    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_hdmuxb4_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_hdmuxb4_rr_sched
// Directed bench for hdmuxb4_rr_sched. Two instances share clock and reset:
// dut_a uses one settle cycle, dut_b uses none. Each row drives inputs just
// after a rising edge and then compares grant, select, valid and busy against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_hdmuxb4_rr_sched;

    logic clk;
    logic rst;

    int checks;
    int errors;

    hdmuxb4_rr_sched_if bus_a ();
    hdmuxb4_rr_sched_if bus_b ();

    hdmuxb4_rr_sched #(.MAXBEATS(8), .TURN_CYC(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    hdmuxb4_rr_sched #(.MAXBEATS(8), .TURN_CYC(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one instance's requester/consumer inputs.
    task automatic applyStimulus(input int which, input logic [3:0] req,
                                 input logic [3:0] last, input logic rdy);
        if (which == 0) begin
            bus_a.req  = req;
            bus_a.last = last;
            bus_a.rdy  = rdy;
        end else begin
            bus_b.req  = req;
            bus_b.last = last;
            bus_b.rdy  = rdy;
        end
    endtask

    // Compare the visible outputs of one instance.
    task automatic checkDut(input int which, input string tag, input logic [3:0] egnt,
                            input logic [1:0] esel, input logic evld, input logic ebusy);
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
        logic       b;
        if (which == 0) begin
            g = bus_a.gnt; s = {bus_a.sl1, bus_a.sl0}; v = bus_a.vld; b = bus_a.busy;
        end else begin
            g = bus_b.gnt; s = {bus_b.sl1, bus_b.sl0}; v = bus_b.vld; b = bus_b.busy;
        end
        checkOutput({tag, ".gnt"},  32'(g), 32'(egnt));
        checkOutput({tag, ".sel"},  32'(s), 32'(esel));
        checkOutput({tag, ".vld"},  32'(v), 32'(evld));
        checkOutput({tag, ".busy"}, 32'(b), 32'(ebusy));
    endtask

    // One cycle: wait for the edge, drive this cycle's inputs, check outputs.
    task automatic runRow(input int which, input logic [3:0] req, input logic [3:0] last,
                          input logic rdy, input logic [3:0] egnt, input logic [1:0] esel,
                          input logic evld, input logic ebusy, input string tag);
        @(posedge clk);
        #1;
        applyStimulus(which, req, last, rdy);
        #1;
        checkDut(which, tag, egnt, esel, evld, ebusy);
    endtask

    // Pulse reset for a cycle and confirm both instances come back idle.
    task automatic doReset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(0, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1, 4'b0000, 4'b0000, 1'b0);
        #1;
        checkDut(0, {tag, "_a"}, 4'b0000, 2'b00, 1'b0, 1'b0);
        checkDut(1, {tag, "_b"}, 4'b0000, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(0, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1, 4'b0000, 4'b0000, 1'b0);
        #12;
        checkDut(0, "reset_a", 4'b0000, 2'b00, 1'b0, 1'b0);
        checkDut(1, "reset_b", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;

        // T1: single requester 0, select already matches, three beats.
        runRow(0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0, "t1_idle");
        runRow(0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b1, "t1_beat1");
        runRow(0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b1, "t1_beat2");
        runRow(0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b1, "t1_beat3");
        runRow(0, 4'b0000, 4'b0000, 1'b1, 4'b0001, 2'b00, 1'b0, 1'b1, "t1_regrant");
        runRow(0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0, "t1_done");

        doReset("t2_reset");

        // T2: all requesting with LAST, rotation 0,1,2,3,0 with one TURN each.
        runRow(0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0, "t2_idle");
        runRow(0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b1, "t2_g0");
        runRow(0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b1, "t2_turn1");
        runRow(0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 2'b01, 1'b1, 1'b1, "t2_g1");
        runRow(0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b1, "t2_turn2");
        runRow(0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b1, "t2_g2");
        runRow(0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b1, "t2_turn3");
        runRow(0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 2'b11, 1'b1, 1'b1, "t2_g3");
        runRow(0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b1, "t2_turn0");
        runRow(0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b1, "t2_g0b");
        runRow(0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b1, "t2_turn_drop");
        runRow(0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0, "t2_no_grant");

        // T3: lone requester 2, forced release after 8 beats with seamless re-grant;
        // a newcomer on beat 8 of the second grant proves the count restarted.
        runRow(0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0, "t3_idle");
        runRow(0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b1, "t3_turn");
        for (int i = 0; i < 8; i++)
            runRow(0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b1, "t3_first");
        for (int i = 0; i < 7; i++)
            runRow(0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b1, "t3_second");
        runRow(0, 4'b1100, 4'b0000, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b1, "t3_beat8");
        runRow(0, 4'b1000, 4'b1000, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b1, "t3_turn3");
        runRow(0, 4'b0000, 4'b0000, 1'b1, 4'b1000, 2'b11, 1'b0, 1'b1, "t3_g3");
        runRow(0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b0, "t3_done");

        // T4: grant to 1 stalled by RDY=0 with LAST high, then the request drops;
        // pointer lands on 1 so requester 3 beats requester 0.
        runRow(0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 2'b11, 1'b0, 1'b0, "t4_idle");
        runRow(0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 2'b01, 1'b0, 1'b1, "t4_turn");
        for (int i = 0; i < 5; i++)
            runRow(0, 4'b0010, 4'b0010, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b1, "t4_stall");
        runRow(0, 4'b1001, 4'b0000, 1'b0, 4'b0010, 2'b01, 1'b0, 1'b1, "t4_drop");
        runRow(0, 4'b1001, 4'b0000, 1'b0, 4'b0000, 2'b11, 1'b0, 1'b1, "t4_turn3");
        runRow(0, 4'b1001, 4'b1000, 1'b1, 4'b1000, 2'b11, 1'b1, 1'b1, "t4_g3");
        runRow(0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b1, "t4_turn0");
        runRow(0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0, "t4_done");

        doReset("t5_reset");

        // T5: reset asserted in the middle of the TURN cycle toward requester 3.
        runRow(0, 4'b1000, 4'b0000, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0, "t5_idle");
        runRow(0, 4'b1000, 4'b0000, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b1, "t5_turn");
        rst = 1'b1;
        #1;
        checkDut(0, "t5_async", 4'b0000, 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkDut(0, "t5_held", 4'b0000, 2'b00, 1'b0, 1'b0);
        runRow(0, 4'b1000, 4'b1000, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b1, "t5_turn_again");
        runRow(0, 4'b0000, 4'b0000, 1'b1, 4'b1000, 2'b11, 1'b0, 1'b1, "t5_g3");
        runRow(0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b0, "t5_done");

        doReset("t6_reset");

        // T6: no settle cycles; requesters 0 and 1 alternate back to back.
        runRow(1, 4'b0011, 4'b0011, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0, "t6_idle");
        runRow(1, 4'b0011, 4'b0011, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b1, "t6_g0");
        runRow(1, 4'b0011, 4'b0011, 1'b1, 4'b0010, 2'b01, 1'b1, 1'b1, "t6_g1");
        runRow(1, 4'b0011, 4'b0011, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b1, "t6_g0b");
        runRow(1, 4'b0011, 4'b0011, 1'b1, 4'b0010, 2'b01, 1'b1, 1'b1, "t6_g1b");
        runRow(1, 4'b0000, 4'b0000, 1'b1, 4'b0001, 2'b00, 1'b0, 1'b1, "t6_g0c");
        runRow(1, 4'b0100, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, "t6_idle2");
        runRow(1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b1, "t6_g2");
        runRow(1, 4'b0000, 4'b0000, 1'b0, 4'b0100, 2'b10, 1'b0, 1'b1, "t6_drop");
        runRow(1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'b10, 1'b0, 1'b0, "t6_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
